// File: rtl/wb_merge_if.sv
// rtl/wb_merge_if.sv - producer/writeback bundle for wb_merge
//
// Purpose: groups the per-channel producer handshake and the register-file
// write port so one interface instance connects producers, wb_merge and the
// register file.
//
// Signals:
//   ch_valid  [NUM_CH]    per-channel result valid          (master -> slave)
//   ch_ready  [NUM_CH]    per-channel FIFO can accept       (slave  -> master)
//   ch_rd     [NUM_CH*5]  destination register, ch i at [5i+:5]
//   ch_data   [NUM_CH*32] raw result / aligned load word, ch i at [32i+:32]
//   ch_fmt    [NUM_CH*3]  RISC-V funct3 load format, ch i at [3i+:3]
//   ch_off    [NUM_CH*2]  byte offset within ch_data, ch i at [2i+:2]
//   rf_we                 register-file write enable       (slave -> master)
//   rf_rd     [5]         register-file write address
//   rf_wdata  [32]        register-file write data
//   busy                  any FIFO non-empty or rf_we high
//
// Modports: master = producers / register-file side, slave = wb_merge.

interface wb_merge_if #(
  parameter int NUM_CH = 3
);
  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH-1:0]    ch_ready;
  logic [NUM_CH*5-1:0]  ch_rd;
  logic [NUM_CH*32-1:0] ch_data;
  logic [NUM_CH*3-1:0]  ch_fmt;
  logic [NUM_CH*2-1:0]  ch_off;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [31:0]          rf_wdata;
  logic                 busy;

  modport master (
    output ch_valid, ch_rd, ch_data, ch_fmt, ch_off,
    input  ch_ready, rf_we, rf_rd, rf_wdata, busy
  );

  modport slave (
    input  ch_valid, ch_rd, ch_data, ch_fmt, ch_off,
    output ch_ready, rf_we, rf_rd, rf_wdata, busy
  );
endinterface

// File: rtl/wb_merge.sv
// rtl/wb_merge.sv - multi-channel writeback merge onto one register-file port
//
// Purpose: NUM_CH producers push {rd, data, fmt, off} into per-channel FIFOs.
// A round-robin arbiter pops one entry per cycle, applies RISC-V load
// formatting (LB/LH/LBU/LHU, otherwise pass-through) and registers the result
// onto the register-file write port. Writes to x0 are popped but not enabled.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   flush  in  synchronous clear of all FIFOs and the pending write
//   bus    wb_merge_if.slave: ch_valid/ch_ready/ch_rd/ch_data/ch_fmt/ch_off
//          per channel, rf_we/rf_rd/rf_wdata write port, busy

module wb_merge #(
  parameter  int NUM_CH = 3,
  parameter  int DEPTH  = 2,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  wb_merge_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  fmt;
    logic [1:0]  off;
  } entry_t;

  // FIFO storage and pointers
  entry_t        mem_q    [NUM_CH][DEPTH];
  entry_t        mem_d    [NUM_CH][DEPTH];
  logic [AW-1:0] wr_ptr_q [NUM_CH];
  logic [AW-1:0] wr_ptr_d [NUM_CH];
  logic [AW-1:0] rd_ptr_q [NUM_CH];
  logic [AW-1:0] rd_ptr_d [NUM_CH];
  logic [CW-1:0] count_q  [NUM_CH];
  logic [CW-1:0] count_d  [NUM_CH];

  // Arbiter and output registers
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  entry_t            head;

  function automatic logic [31:0] format_load(input entry_t e);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = e.data >> {e.off, 3'b000};
    half_sh = e.data >> {e.off[1], 4'b0000};
    case (e.fmt)
      3'b000:  format_load = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  format_load = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  format_load = {24'h0, byte_sh[7:0]};
      3'b101:  format_load = {16'h0, half_sh[15:0]};
      default: format_load = e.data;
    endcase
  endfunction

  // Status from registered counts only, so ch_ready never sees ch_valid.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]     = (count_q[i] == CW'(DEPTH));
      nonempty[i] = (count_q[i] != '0);
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin : arb
    logic [PW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NUM_CH);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign head = mem_q[grant_idx][rd_ptr_q[grant_idx]];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      push[i] = bus.ch_valid[i] && !full[i] && !flush;
      pop[i]  = grant_vld && (grant_idx == PW'(i)) && !flush;
    end
  end

  // FIFO next state
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i]].rd   = bus.ch_rd[5*i +: 5];
          mem_d[i][wr_ptr_q[i]].data = bus.ch_data[32*i +: 32];
          mem_d[i][wr_ptr_q[i]].fmt  = bus.ch_fmt[3*i +: 3];
          mem_d[i][wr_ptr_q[i]].off  = bus.ch_off[2*i +: 2];
          wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count_d[i] = count_q[i] + CW'(1);
          2'b01:   count_d[i] = count_q[i] - CW'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  // Write-port next state; address/data hold when nothing is granted.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    rr_ptr_d   = rr_ptr_q;
    if (!flush && grant_vld) begin
      rf_we_d    = (head.rd != 5'd0);
      rf_rd_d    = head.rd;
      rf_wdata_d = format_load(head);
      rr_ptr_d   = grant_idx;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q   <= PW'(NUM_CH - 1);
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.ch_ready = ~full;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = (|nonempty) | rf_we_q;

endmodule

// File: tb/tb_wb_merge.sv
// tb/tb_wb_merge.sv - self-checking bench for wb_merge

module tb_wb_merge;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  wb_merge_if #(.NUM_CH(NUM_CH)) bus ();

  wb_merge #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  fmt;
    logic [1:0]  off;
  } ment_t;

  ment_t       mq [NUM_CH][$];
  int          m_ptr   = NUM_CH - 1;
  logic        m_we    = 1'b0;
  logic [4:0]  m_rd    = 5'd0;
  logic [31:0] m_wdata = 32'd0;

  function automatic logic [31:0] model_fmt(input ment_t e);
    int unsigned v;
    case (e.fmt)
      3'b000: begin
        v = (e.data >> (8 * e.off)) & 32'hFF;
        if (v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b100: v = (e.data >> (8 * e.off)) & 32'hFF;
      3'b001: begin
        v = (e.data >> (16 * e.off[1])) & 32'hFFFF;
        if (v >= 32768) v = v + 32'hFFFF_0000;
      end
      3'b101: v = (e.data >> (16 * e.off[1])) & 32'hFFFF;
      default: v = e.data;
    endcase
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
        m_ptr = NUM_CH - 1; m_we = 1'b0; m_rd = 5'd0; m_wdata = 32'd0;
      end else if (flush) begin
        for (int i = 0; i < NUM_CH; i++) mq[i].delete();
        m_we = 1'b0;
      end else begin
        int sz [NUM_CH];
        int g;
        ment_t e;
        for (int i = 0; i < NUM_CH; i++) sz[i] = mq[i].size();
        g = -1;
        for (int k = 1; k <= NUM_CH; k++)
          if (g < 0 && sz[(m_ptr + k) % NUM_CH] > 0) g = (m_ptr + k) % NUM_CH;
        m_we = 1'b0;
        if (g >= 0) begin
          e = mq[g].pop_front();
          m_we = (e.rd != 0);
          m_rd = e.rd;
          m_wdata = model_fmt(e);
          m_ptr = g;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (bus.ch_valid[i] && sz[i] < DEPTH) begin
            e.rd = bus.ch_rd[5*i +: 5];
            e.data = bus.ch_data[32*i +: 32];
            e.fmt = bus.ch_fmt[3*i +: 3];
            e.off = bus.ch_off[2*i +: 2];
            mq[i].push_back(e);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [NUM_CH-1:0] exp_rdy;
        logic exp_busy;
        exp_busy = m_we;
        for (int i = 0; i < NUM_CH; i++) begin
          exp_rdy[i] = (mq[i].size() < DEPTH);
          if (mq[i].size() > 0) exp_busy = 1'b1;
        end
        check("cmp_rf_we", 32'(bus.rf_we), 32'(m_we));
        check("cmp_rf_rd", 32'(bus.rf_rd), 32'(m_rd));
        check("cmp_rf_wdata", bus.rf_wdata, m_wdata);
        check("cmp_ch_ready", 32'(bus.ch_ready), 32'(exp_rdy));
        check("cmp_busy", 32'(bus.busy), 32'(exp_busy));
      end
    end
  end

  // Log of writes to rd 20..23 for the backpressure test
  int wlog [$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rf_we && bus.rf_rd >= 5'd20 && bus.rf_rd <= 5'd23)
        wlog.push_back(int'(bus.rf_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ch(input int ch, input int rd, input logic [31:0] data,
                        input logic [2:0] fmt, input logic [1:0] off);
    bus.ch_rd[5*ch +: 5]    = rd[4:0];
    bus.ch_data[32*ch +: 32] = data;
    bus.ch_fmt[3*ch +: 3]   = fmt;
    bus.ch_off[2*ch +: 2]   = off;
  endtask

  task automatic push1(input int ch, input int rd, input logic [31:0] data,
                       input logic [2:0] fmt, input logic [1:0] off);
    set_ch(ch, rd, data, fmt, off);
    bus.ch_valid[ch] = 1'b1;
    @(negedge clk);
    bus.ch_valid[ch] = 1'b0;
  endtask

  logic [2:0]  fv_fmt [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  fv_off [5] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0};
  logic [31:0] fv_exp [5] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00F0,
                              32'hFFFF_80F0, 32'h0000_7F01};

  initial begin
    int k;
    int budget;
    logic acc;
    logic saw_full;

    bus.ch_valid = '0; bus.ch_rd = '0; bus.ch_data = '0;
    bus.ch_fmt = '0; bus.ch_off = '0;

    // Reset with all valids high
    #1 rst_n = 1'b0;
    bus.ch_valid = 3'b111;
    #2;
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_ch_ready", 32'(bus.ch_ready), 32'b111);
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.ch_valid = '0;
    rst_n = 1'b1;
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    @(negedge clk);

    // Single push, 2-cycle latency
    push1(0, 5, 32'h1234_5678, 3'b010, 2'd0);
    check("lat_not_early", 32'(bus.rf_we), 32'd0);
    @(negedge clk);
    check("lat_we", 32'(bus.rf_we), 32'd1);
    check("lat_rd", 32'(bus.rf_rd), 32'd5);
    check("lat_data", bus.rf_wdata, 32'h1234_5678);

    // Load formatting on ch1
    for (int i = 0; i < 5; i++) begin
      push1(1, 7, 32'h80F0_7F01, fv_fmt[i], fv_off[i]);
      @(negedge clk);
      check("fmt_we", 32'(bus.rf_we), 32'd1);
      check($sformatf("fmt_data_%0d", i), bus.rf_wdata, fv_exp[i]);
    end

    // Park pointer on ch2, then two overlapping bursts
    push1(2, 9, 32'h0000_0009, 3'b010, 2'd0);
    @(negedge clk);
    set_ch(0, 1, 32'hA0, 3'b010, 0); set_ch(1, 2, 32'hA1, 3'b010, 0);
    set_ch(2, 3, 32'hA2, 3'b010, 0);
    bus.ch_valid = 3'b111;
    @(negedge clk);
    bus.ch_valid = '0;
    @(negedge clk);
    check("burst_rd_1", 32'(bus.rf_rd), 32'd1);
    set_ch(0, 4, 32'hB0, 3'b010, 0); set_ch(1, 5, 32'hB1, 3'b010, 0);
    set_ch(2, 6, 32'hB2, 3'b010, 0);
    bus.ch_valid = 3'b111;
    @(negedge clk);
    bus.ch_valid = '0;
    check("burst_rd_2", 32'(bus.rf_rd), 32'd2);
    for (int r = 3; r <= 6; r++) begin
      @(negedge clk);
      check($sformatf("burst_rd_%0d", r), 32'(bus.rf_rd), 32'(r));
      check("burst_we", 32'(bus.rf_we), 32'd1);
    end
    @(negedge clk);

    // Backpressure on ch2 while ch0/ch1 flood
    set_ch(0, 10, 32'hF0, 3'b010, 0);
    set_ch(1, 11, 32'hF1, 3'b010, 0);
    set_ch(2, 20, 32'hC200_0000, 3'b011, 0);
    bus.ch_valid = 3'b111;
    k = 0; budget = 0; saw_full = 1'b0;
    while (k < 4 && budget < 40) begin
      acc = bus.ch_ready[2];
      if (!acc) saw_full = 1'b1;
      @(negedge clk);
      budget++;
      if (acc) begin
        k++;
        if (k < 4) set_ch(2, 20 + k, 32'hC200_0000 + k, 3'b011, 0);
        else bus.ch_valid[2] = 1'b0;
      end
    end
    bus.ch_valid = '0;
    check("bp_accepts", 32'(k), 32'd4);
    check("bp_saw_full", 32'(saw_full), 32'd1);
    budget = 0;
    while (bus.busy && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("bp_drained", 32'(bus.busy), 32'd0);
    check("bp_wcount", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check($sformatf("bp_order_%0d", i), 32'(wlog[i]), 32'(20 + i));
    @(negedge clk);

    // Write to x0
    push1(0, 0, 32'hDEAD_BEEF, 3'b010, 2'd0);
    @(negedge clk);
    check("x0_we", 32'(bus.rf_we), 32'd0);
    check("x0_rd", 32'(bus.rf_rd), 32'd0);
    check("x0_data", bus.rf_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("x0_busy", 32'(bus.busy), 32'd0);

    // Push then flush one cycle later
    set_ch(1, 12, 32'h5555_5555, 3'b010, 0);
    bus.ch_valid[1] = 1'b1;
    @(negedge clk);
    bus.ch_valid[1] = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_we", 32'(bus.rf_we), 32'd0);
    check("flush_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("flush_we_after", 32'(bus.rf_we), 32'd0);

    // Asynchronous reset while two FIFOs hold entries
    set_ch(0, 13, 32'h1, 3'b010, 0); set_ch(1, 14, 32'h2, 3'b010, 0);
    bus.ch_valid = 3'b011;
    @(negedge clk);
    bus.ch_valid = '0;
    check("arst_pre_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.rf_we), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_ready", 32'(bus.ch_ready), 32'b111);
    check("arst_rd", 32'(bus.rf_rd), 32'd0);
    check("arst_wdata", bus.rf_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_no_write", 32'(bus.rf_we), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Parametrised writeback stage that merges results from NUM_CH producers (ALU pipe, load unit, multicycle mul/div, ...) onto the single register-file write port.
- Each channel has a valid/ready input handshake and a per-channel FIFO.
- Loads are formatted per RISC-V funct3: byte/half extraction plus sign/zero extension.
- A round-robin arbiter drains one entry per cycle into a registered write port; sits between execute/memory units and the register file.

Parameters:
- NUM_CH, 3, number of producer channels (>=1).
- DEPTH, 2, entries per channel FIFO (power of two, >=2).
- CW, $clog2(DEPTH+1), width of per-channel occupancy count (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all FIFOs and of the pending output write.
- ch_valid  in  NUM_CH  per-channel result valid.
- ch_ready  out  NUM_CH  per-channel FIFO can accept.
- ch_rd  in  NUM_CH*5  destination register, channel i at [5i+:5].
- ch_data  in  NUM_CH*32  raw result / aligned load word, channel i at [32i+:32].
- ch_fmt  in  NUM_CH*3  format (RISC-V funct3): 000 LB, 001 LH, 100 LBU, 101 LHU; any other value passes data through.
- ch_off  in  NUM_CH*2  byte offset of the load within ch_data.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  write address (registered).
- rf_wdata  out  32  write data (registered).
- busy  out  1  high when any FIFO is non-empty or rf_we is high.

Behaviour:
- Clock and reset: one clock, clk. rst_n asynchronous active-low. While rst_n=0: all FIFOs empty, rf_we=0, rf_rd=0, rf_wdata=0, RR pointer=NUM_CH-1 (so channel 0 wins first), busy=0. ch_ready=1 for every channel.
- ch_ready[i] = !full[i], decoded from the registered count only. It never depends combinationally on ch_valid.
- Enqueue: on an edge with ch_valid[i] && ch_ready[i] && !flush, push {rd, data, fmt, off}. Valid asserted while ready=0 is ignored; the producer must hold valid and data until accepted.
- Formatting is applied at dequeue:
  - LB: sign-extend byte at off.
  - LBU: zero-extend byte at off.
  - LH: sign-extend half at off[1] (off[0] ignored).
  - LHU: zero-extend half at off[1].
  - Anything else: data unchanged.
- Arbitration: each cycle, grant the first non-empty channel searching from ptr+1 modulo NUM_CH. On grant, pop that FIFO, set ptr = granted index, and register the result into the rf_* outputs. With no requester, rf_we=0 next cycle; rf_rd and rf_wdata hold their values.
- rd = x0: the entry is popped and rf_rd/rf_wdata load normally, but rf_we=0.
- Latency: entry accepted at edge t gives rf_we high in the cycle after edge t+1 (2 cycles) when uncontended. Throughput is 1 write per cycle aggregate.
- Simultaneous push and pop on the same channel: count unchanged. A push into a full FIFO is allowed only if ch_ready was high; ready does not account for the same-cycle pop.
- Pointer wrap: with NUM_CH=3 and all channels busy, grant order is 0,1,2,0,...
- Flush: at the flushing edge all counts go to 0, rf_we goes to 0, and same-cycle pushes are dropped. ptr is unchanged.
- Reset asserted mid-operation: immediate clear, independent of clk.
- busy = |count_nonzero | rf_we.
- No ordering guarantee across channels. Order within a channel is preserved.

Test Plan:
- Reset with ch_valid all high -> rf_we=0, ch_ready=3'b111, busy=0. After release, one push on ch0 (rd=5, data=0x1234_5678, fmt=010) -> rf_we=1, rf_rd=5, rf_wdata=0x1234_5678 exactly 2 cycles later.
- ch1 pushes of data=0x80F0_7F01 with fmt/off:
  - LB, off=1 -> 0x0000_007F.
  - LB, off=3 -> 0xFFFF_FF80.
  - LBU, off=2 -> 0x0000_00F0.
  - LH, off=2 -> 0xFFFF_80F0.
  - LHU, off=0 -> 0x0000_7F01.
- All 3 channels push rd=1,2,3 in the same cycle -> writes appear on consecutive cycles in order 1,2,3. A second burst continues round-robin from ptr+1.
- Hold ch2 valid with no drain contention blocked: fill DEPTH=2 while ch0 floods -> ch_ready[2]=0 after 2 accepts. Each accepted ch2 entry appears exactly once, in order.
- Push rd=0, data=0xDEAD_BEEF -> no rf_we pulse, busy drops afterwards. Push then flush one cycle later -> no write occurs, busy=0.
- Assert rst_n=0 asynchronously between edges while FIFOs hold 2 entries -> outputs clear immediately, and no write occurs after release.
